val2_shift_seq: RTL



---
 rtl/val2_shift_seq_pkg.sv | 89 ++++++++
 rtl/val2_shift_seq_if.sv | 42 ++++
 rtl/val2_step_shifter.sv | 53 +++++
 rtl/val2_shift_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/val2_shift_seq_pkg.sv
// Shared definitions for the Val2 operand sequencer.
// Supplies the register width, shift-op codes, FSM state codes and the
// operand decode helper used at accept time. The shared defines are given
// fallback values here so the slice builds stand-alone.
// Optional feature macro: VAL2_CARRY_OUT_EN (used by the other files).

`ifndef REGISTER_LEN
`define REGISTER_LEN 32
`endif
`ifndef LSL_SHIFT_STATE
`define LSL_SHIFT_STATE 2'b00
`endif
`ifndef LSR_SHIFT_STATE
`define LSR_SHIFT_STATE 2'b01
`endif
`ifndef ASR_SHIFT_STATE
`define ASR_SHIFT_STATE 2'b10
`endif
`ifndef ROR_SHIFT_STATE
`define ROR_SHIFT_STATE 2'b11
`endif
`ifndef V2S_IDLE
`define V2S_IDLE 2'd0
`endif
`ifndef V2S_SHIFT
`define V2S_SHIFT 2'd1
`endif
`ifndef V2S_DONE
`define V2S_DONE 2'd2
`endif
`ifndef V2S_MAX_AMT
`define V2S_MAX_AMT 32
`endif

package val2_shift_seq_pkg;

  localparam int unsigned REG_W   = `REGISTER_LEN;
  localparam int unsigned AMT_W   = 6;               // holds 0..32
  localparam int unsigned IDX_W   = $clog2(REG_W);
  localparam int unsigned MAX_AMT = `V2S_MAX_AMT;

  localparam logic [1:0] OP_LSL = `LSL_SHIFT_STATE;
  localparam logic [1:0] OP_LSR = `LSR_SHIFT_STATE;
  localparam logic [1:0] OP_ASR = `ASR_SHIFT_STATE;
  localparam logic [1:0] OP_ROR = `ROR_SHIFT_STATE;

  typedef enum logic [1:0] {
    ST_IDLE  = `V2S_IDLE,
    ST_SHIFT = `V2S_SHIFT,
    ST_DONE  = `V2S_DONE
  } state_t;

  // Decoded operand latched at accept: working value, op and total amount.
  typedef struct packed {
    logic [REG_W-1:0] w;
    logic [1:0]       op;
    logic [AMT_W-1:0] amt;
  } dec_t;

  function automatic dec_t decode(input logic [REG_W-1:0] rm,
                                  input logic [7:0]       rs_lo,
                                  input logic [11:0]      so,
                                  input logic             imm,
                                  input logic             mem);
    dec_t d;
    d.w   = rm;
    d.op  = so[6:5];
    d.amt = '0;
    if (mem) begin
      d.w  = REG_W'(so);
      d.op = OP_LSL;
    end else if (imm) begin
      d.w   = REG_W'(so[7:0]);
      d.op  = OP_ROR;
      d.amt = AMT_W'({so[11:8], 1'b0});
    end else if (!so[4]) begin
      d.amt = AMT_W'(so[11:7]);
    end else if (so[6:5] == OP_ROR) begin
      // Rotation is modulo the register width.
      d.amt = AMT_W'(rs_lo[4:0]);
    end else if (rs_lo > 8'(MAX_AMT)) begin
      d.amt = AMT_W'(MAX_AMT);
    end else begin
      d.amt = AMT_W'(rs_lo);
    end
    return d;
  endfunction

endpackage

// File: rtl/val2_shift_seq_if.sv
// Request/response bundle between the EX-stage control and the Val2 sequencer.
// master: requester (drives start and operands, sees ready/busy/done/result).
// slave : sequencer.
// With VAL2_CARRY_OUT_EN defined, carry_in and shifter_carry are added.

interface val2_shift_seq_if;
  import val2_shift_seq_pkg::*;

  logic             start;
  logic [REG_W-1:0] val_rm;
  logic [REG_W-1:0] val_rs;
  logic [11:0]      shift_operand;
  logic             immediate;
  logic             is_mem_command;
  logic             ready;
  logic             busy;
  logic             done;
  logic [REG_W-1:0] val2_out;
`ifdef VAL2_CARRY_OUT_EN
  logic             carry_in;
  logic             shifter_carry;
`endif

  modport master (
    output start, val_rm, val_rs, shift_operand, immediate, is_mem_command,
`ifdef VAL2_CARRY_OUT_EN
    output carry_in,
    input  shifter_carry,
`endif
    input  ready, busy, done, val2_out
  );

  modport slave (
    input  start, val_rm, val_rs, shift_operand, immediate, is_mem_command,
`ifdef VAL2_CARRY_OUT_EN
    input  carry_in,
    output shifter_carry,
`endif
    output ready, busy, done, val2_out
  );

endinterface

// File: rtl/val2_step_shifter.sv
// Narrow combinational shifter: applies k (0..SHIFT_STEP) positions of op to w.
// Ports: w (in), op (in), k (in), w_out (out); with VAL2_CARRY_OUT_EN also
// carry (out) = last bit shifted out during this step.

module val2_step_shifter
  import val2_shift_seq_pkg::*;
#(
  parameter  int unsigned SHIFT_STEP = 4,
  localparam int unsigned K_W        = $clog2(SHIFT_STEP + 1)
) (
  input  logic [REG_W-1:0] w,
  input  logic [1:0]       op,
  input  logic [K_W-1:0]   k,
`ifdef VAL2_CARRY_OUT_EN
  output logic             carry,
`endif
  output logic [REG_W-1:0] w_out
);

  logic [AMT_W-1:0] k_rot;

  // Shift result; ROR uses the complementary left shift for the wrap.
  always_comb begin
    k_rot = AMT_W'(REG_W) - AMT_W'(k);
    unique case (op)
      OP_LSL:  w_out = w << k;
      OP_LSR:  w_out = w >> k;
      OP_ASR:  w_out = $unsigned($signed(w) >>> k);
      default: w_out = (w >> k) | (w << k_rot);
    endcase
  end

`ifdef VAL2_CARRY_OUT_EN
  logic [IDX_W-1:0] idx_l;
  logic [IDX_W-1:0] idx_r;

  // Last bit out: w[32-k] for LSL, w[k-1] for LSR/ASR, new MSB for ROR.
  always_comb begin
    idx_l = IDX_W'(AMT_W'(REG_W) - AMT_W'(k));
    idx_r = IDX_W'(AMT_W'(k) - AMT_W'(1));
    carry = 1'b0;
    if (k != '0) begin
      unique case (op)
        OP_LSL:  carry = w[idx_l];
        OP_LSR,
        OP_ASR:  carry = w[idx_r];
        default: carry = w_out[REG_W-1];
      endcase
    end
  end
`endif

endmodule

// File: rtl/val2_shift_seq.sv
// Multi-cycle Val2 sequencer: decodes operand-2 at accept, then shifts the
// working value by up to SHIFT_STEP positions per cycle until done.
// Ports: clk, rst (sync, active-high), bus (val2_shift_seq_if.slave).
// Optional macro VAL2_CARRY_OUT_EN adds carry_in/shifter_carry on the bus.

module val2_shift_seq
  import val2_shift_seq_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 4
) (
  input logic               clk,
  input logic               rst,
  val2_shift_seq_if.slave   bus
);

  localparam int unsigned K_W = $clog2(SHIFT_STEP + 1);

  state_t           state, state_n;
  logic [REG_W-1:0] w, w_n, step_w, val2_q;
  logic [1:0]       op, op_n;
  logic [AMT_W-1:0] rem, rem_n;
  logic [K_W-1:0]   k;
  logic             ready_q, busy_q, done_q;
  dec_t             dec;

`ifdef VAL2_CARRY_OUT_EN
  logic carry_w, carry_w_n, step_carry, carry_q;
`endif

  // Per-cycle amount: min(remaining, SHIFT_STEP).
  assign k = (rem < AMT_W'(SHIFT_STEP)) ? K_W'(rem) : K_W'(SHIFT_STEP);

  val2_step_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_step (
    .w     (w),
    .op    (op),
    .k     (k),
`ifdef VAL2_CARRY_OUT_EN
    .carry (step_carry),
`endif
    .w_out (step_w)
  );

  // Next state and working-register updates. ASR needs no separate sign
  // register: every arithmetic step preserves bit 31 as latched at accept.
  always_comb begin
    state_n = state;
    w_n     = w;
    op_n    = op;
    rem_n   = rem;
`ifdef VAL2_CARRY_OUT_EN
    carry_w_n = carry_w;
`endif
    dec = decode(bus.val_rm, bus.val_rs[7:0], bus.shift_operand,
                 bus.immediate, bus.is_mem_command);
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          w_n   = dec.w;
          op_n  = dec.op;
          rem_n = dec.amt;
`ifdef VAL2_CARRY_OUT_EN
          carry_w_n = bus.carry_in;
`endif
          state_n = (dec.amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_n   = step_w;
        rem_n = rem - AMT_W'(k);
`ifdef VAL2_CARRY_OUT_EN
        carry_w_n = step_carry;
`endif
        if (rem_n == '0) state_n = ST_DONE;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs; result loads on the edge entering DONE so
  // it is valid in the same cycle as the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      w       <= '0;
      op      <= OP_LSL;
      rem     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      val2_q  <= '0;
`ifdef VAL2_CARRY_OUT_EN
      carry_w <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      w       <= w_n;
      op      <= op_n;
      rem     <= rem_n;
      ready_q <= (state_n == ST_IDLE);
      busy_q  <= (state_n != ST_IDLE);
      done_q  <= (state_n == ST_DONE);
      if (state_n == ST_DONE) val2_q <= w_n;
`ifdef VAL2_CARRY_OUT_EN
      carry_w <= carry_w_n;
      if (state_n == ST_DONE) carry_q <= carry_w_n;
`endif
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.val2_out = val2_q;
`ifdef VAL2_CARRY_OUT_EN
  assign bus.shifter_carry = carry_q;
`endif

endmodule
